// File: rtl/ahb_burst_master.sv
// rtl/ahb_burst_master.sv - AHB-Lite burst master driven by a simple command port
module ahb_burst_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wdata_ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic [1:0]            HRESP
);

  localparam int       BYTES     = DATA_WIDTH / 8;
  localparam logic [2:0] SIZE    = (DATA_WIDTH == 64) ? 3'b011 : 3'b010;
  localparam logic [1:0] T_IDLE  = 2'b00;
  localparam logic [1:0] T_NSEQ  = 2'b10;
  localparam logic [1:0] T_SEQ   = 2'b11;
  localparam logic [1:0] R_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_BURST = 3'd2,
    S_LAST  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t      state, state_n;
  logic [7:0]  cnt;          // address phases still to issue after the current one
  logic        addr_acc;     // current address phase accepted at this edge
  logic        data_ok;      // data phase completes with OKAY at this edge
  logic        finish_ok;
  logic        finish_err;
  logic [11:0] span_end;
  logic [2:0]  burst_sel;

  assign HSIZE = SIZE;

  // Pick the burst encoding for a new command; fixed-length only when the burst stays inside 1KB
  always_comb begin
    span_end  = {2'b00, cmd_addr[9:0]} + (({4'd0, cmd_len} + 12'd1) * 12'(BYTES));
    burst_sel = 3'b001;
    case (cmd_len)
      8'd0:    burst_sel = 3'b000;
      8'd3:    if (span_end <= 12'd1024) burst_sel = 3'b011;
      8'd7:    if (span_end <= 12'd1024) burst_sel = 3'b101;
      8'd15:   if (span_end <= 12'd1024) burst_sel = 3'b111;
      default: burst_sel = 3'b001;
    endcase
  end

  // State register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next state, bus transfer type and handshake strobes
  always_comb begin
    state_n    = state;
    cmd_ready  = 1'b0;
    HTRANS     = T_IDLE;
    addr_acc   = 1'b0;
    data_ok    = 1'b0;
    finish_ok  = 1'b0;
    finish_err = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_n = S_ADDR;
      end
      S_ADDR: begin
        HTRANS = T_NSEQ;
        if (HREADY) begin
          addr_acc = 1'b1;
          state_n  = (cnt == 8'd0) ? S_LAST : S_BURST;
        end
      end
      S_BURST: begin
        // crossing into a new 1KB page restarts the burst with NONSEQ
        HTRANS = (HADDR[9:0] == 10'd0) ? T_NSEQ : T_SEQ;
        if (HRESP != R_OKAY) begin
          finish_err = HREADY;
          state_n    = HREADY ? S_IDLE : S_ERR;
        end else if (HREADY) begin
          addr_acc = 1'b1;
          data_ok  = 1'b1;
          state_n  = (cnt == 8'd0) ? S_LAST : S_BURST;
        end
      end
      S_LAST: begin
        if (HRESP != R_OKAY) begin
          finish_err = HREADY;
          state_n    = HREADY ? S_IDLE : S_ERR;
        end else if (HREADY) begin
          data_ok   = 1'b1;
          finish_ok = 1'b1;
          state_n   = S_IDLE;
        end
      end
      S_ERR: begin
        if (HREADY) begin
          finish_err = 1'b1;
          state_n    = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign wdata_ack = addr_acc & HWRITE;

  // Command latch, address stepping, write/read data registers and completion strobes
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      HADDR       <= '0;
      HWRITE      <= 1'b0;
      HBURST      <= 3'b000;
      HWDATA      <= '0;
      cnt         <= 8'd0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      done        <= finish_ok | finish_err;
      err         <= finish_err;
      if (cmd_valid && cmd_ready) begin
        HADDR  <= cmd_addr;
        HWRITE <= cmd_write;
        HBURST <= burst_sel;
        cnt    <= cmd_len;
      end
      if (addr_acc && cnt != 8'd0) begin
        HADDR <= HADDR + ADDR_WIDTH'(BYTES);
        cnt   <= cnt - 8'd1;
      end
      if (addr_acc && HWRITE) HWDATA <= wdata;
      if (data_ok && !HWRITE) begin
        rdata       <= HRDATA;
        rdata_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ahb_burst_master.sv
// tb/tb_ahb_burst_master.sv - self-checking bench for ahb_burst_master
module tb_ahb_burst_master;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [31:0] wdata = '0;
  logic [31:0] HRDATA = '0;
  logic        HREADY = 1'b1;
  logic [1:0]  HRESP = 2'b00;
  logic        cmd_ready, wdata_ack, rdata_valid, done, err, HWRITE;
  logic [31:0] rdata, HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;

  int tests = 0;
  int fails = 0;
  logic [1:0] ekind = 2'b01;

  always #5 HCLK = ~HCLK;

  ahb_burst_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata(wdata), .wdata_ack(wdata_ack),
    .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .err(err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  // w, start address, len, beat to stall, stall cycles, beat that errors, expected HBURST, write seed
  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [7:0]  l;
    int          wb;
    int          wn;
    int          eb;
    logic [2:0]  xb;
    logic [31:0] seed;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] wpat(input logic [31:0] seed, input int i);
    return seed + 32'(i - 1) * 32'h0102_0304;
  endfunction

  function automatic logic [31:0] rpat(input logic [31:0] a);
    return ~a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [2:0] model_burst(input logic [31:0] a, input int l);
    int beats;
    bit fits;
    beats = l + 1;
    fits  = (int'(a[9:0]) + beats * 4) <= 1024;
    if (beats == 1) return 3'b000;
    if (fits && beats == 4) return 3'b011;
    if (fits && beats == 8) return 3'b101;
    if (fits && beats == 16) return 3'b111;
    return 3'b001;
  endfunction

  // Issue one command and act as the slave; dp is the beat whose data phase is on the bus.
  task automatic run_cmd(input vec_t v);
    int beats, exp_acc, acc, acks, rvs, dp, waited, ephase, lat;
    bit got_done, exp_err, rv_due, stall_chk, idle_due, took;
    logic [31:0] exp_rd, st_addr, exp_a;
    logic [1:0]  st_trans, exp_t;
    beats = int'(v.l) + 1;
    exp_err = (v.eb != 0);
    exp_acc = exp_err ? v.eb : beats;
    acc = 0; acks = 0; rvs = 0; dp = 0; waited = 0; ephase = 0; lat = 0;
    got_done = 0; rv_due = 0; stall_chk = 0; idle_due = 0;
    exp_rd = '0; st_addr = '0; st_trans = '0;
    @(negedge HCLK);
    HREADY = 1'b1; HRESP = 2'b00;
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = v.w; cmd_addr = v.a; cmd_len = v.l;
    wdata = wpat(v.seed, 1);
    @(posedge HCLK);
    #1 cmd_valid = 1'b0;
    for (int cyc = 1; cyc < 1000 && !got_done; cyc++) begin
      @(negedge HCLK);
      check("rdata_valid", 32'(rdata_valid), 32'(rv_due));
      if (rv_due) check("rdata", rdata, exp_rd);
      if (stall_chk) begin
        check("haddr_hold", HADDR, st_addr);
        check("htrans_hold", 32'(HTRANS), 32'(st_trans));
      end
      if (idle_due) check("htrans_idle_after_err", 32'(HTRANS), 32'd0);
      rv_due = 0; stall_chk = 0; idle_due = 0;
      if (done) begin
        got_done = 1;
        lat = cyc;
      end else begin
        HREADY = 1'b1; HRESP = 2'b00; HRDATA = $urandom;
        wdata = wpat(v.seed, acks + 1);
        if (dp != 0) begin
          HRDATA = rpat(v.a + 32'(4 * (dp - 1)));
          if (dp == v.eb) begin
            HRESP  = ekind;
            HREADY = (ephase == 1);
          end else if (dp == v.wb && waited < v.wn) begin
            HREADY = 1'b0;
            waited++;
          end
        end
        #1;
        took = HREADY && HTRANS[1];
        check("wdata_ack", 32'(wdata_ack), 32'(v.w && took));
        if (took) begin
          acc++;
          exp_a = v.a + 32'(4 * (acc - 1));
          exp_t = (acc == 1 || exp_a[9:0] == 10'd0) ? 2'b10 : 2'b11;
          check("beat_in_range", 32'(acc <= exp_acc), 32'd1);
          check("haddr", HADDR, exp_a);
          check("htrans", 32'(HTRANS), 32'(exp_t));
          check("hburst", 32'(HBURST), 32'(v.xb));
          check("hwrite", 32'(HWRITE), 32'(v.w));
          check("hsize", 32'(HSIZE), 32'd2);
          if (v.w) acks++;
        end
        if (dp != 0 && HREADY && HRESP == 2'b00) begin
          if (v.w) check("hwdata", HWDATA, wpat(v.seed, dp));
          else begin
            rv_due = 1;
            exp_rd = rpat(v.a + 32'(4 * (dp - 1)));
            rvs++;
          end
        end
        if (!HREADY && HTRANS[1] && dp != v.eb) begin
          stall_chk = 1; st_addr = HADDR; st_trans = HTRANS;
        end
        if (dp != 0 && dp == v.eb && ephase == 0) idle_due = 1;
        @(posedge HCLK);
        if (dp != 0 && dp == v.eb && !HREADY) ephase = 1;
        if (HREADY) dp = took ? acc : 0;
      end
    end
    check("done_seen", 32'(got_done), 32'd1);
    if (got_done) begin
      check("err", 32'(err), 32'(exp_err));
      check("cmd_ready_at_done", 32'(cmd_ready), 32'd1);
      check("addr_phases", 32'(acc), 32'(exp_acc));
      check("wdata_acks", 32'(acks), 32'(v.w ? exp_acc : 0));
      check("rdata_beats", 32'(rvs), 32'(v.w ? 0 : (exp_err ? v.eb - 1 : beats)));
      if (v.wn == 0 && !exp_err) check("latency", 32'(lat), 32'(int'(v.l) + 3));
      @(negedge HCLK);
      check("done_strobe", 32'(done), 32'd0);
    end
  endtask

  vec_t tbl[12];
  vec_t r;

  initial begin
    tbl[0]  = '{1'b1, 32'h0000_0100, 8'd0,   0, 0, 0, 3'b000, 32'hDEAD_BEEF};
    tbl[1]  = '{1'b0, 32'h0000_0200, 8'd3,   2, 2, 0, 3'b011, 32'h0};
    tbl[2]  = '{1'b1, 32'h0000_03F8, 8'd5,   0, 0, 0, 3'b001, 32'h1111_0000};
    tbl[3]  = '{1'b1, 32'h0000_0000, 8'd7,   0, 0, 3, 3'b101, 32'h2222_0000};
    tbl[4]  = '{1'b0, 32'h0000_03C0, 8'd15,  0, 0, 0, 3'b111, 32'h0};
    tbl[5]  = '{1'b0, 32'h0000_03C4, 8'd15,  0, 0, 0, 3'b001, 32'h0};
    tbl[6]  = '{1'b1, 32'h0000_03F0, 8'd3,   4, 1, 0, 3'b011, 32'h3333_0000};
    tbl[7]  = '{1'b0, 32'h0000_03F4, 8'd3,   0, 0, 0, 3'b001, 32'h0};
    tbl[8]  = '{1'b0, 32'h0001_0000, 8'd255, 0, 0, 0, 3'b001, 32'h0};
    tbl[9]  = '{1'b0, 32'h0000_0080, 8'd7,   0, 0, 8, 3'b101, 32'h0};
    tbl[10] = '{1'b1, 32'h0000_0010, 8'd1,   0, 0, 0, 3'b001, 32'h4444_0000};
    tbl[11] = '{1'b0, 32'h0000_0040, 8'd0,   0, 0, 1, 3'b000, 32'h0};

    #1 HRESET = 1'b1;
    #2;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_htrans", 32'(HTRANS), 32'd0);
    check("rst_haddr", HADDR, 32'd0);
    check("rst_hburst", 32'(HBURST), 32'd0);
    check("rst_hsize", 32'(HSIZE), 32'd2);
    check("rst_done", 32'(done), 32'd0);
    @(negedge HCLK);
    HRESET = 1'b0;

    for (int i = 0; i < 12; i++) begin
      ekind = 2'b01;
      run_cmd(tbl[i]);
    end

    for (int k = 0; k < 24; k++) begin
      r.w = 1'($urandom_range(0, 1));
      r.a = ($urandom & 32'h0FFF_F000) | (32'($urandom_range(0, 1023)) << 2);
      if ($urandom_range(0, 2) == 0) r.a[9:0] = 10'(1024 - 4 * $urandom_range(1, 20));
      case ($urandom_range(0, 4))
        0:       r.l = 8'd0;
        1:       r.l = 8'd3;
        2:       r.l = 8'd7;
        3:       r.l = 8'd15;
        default: r.l = 8'($urandom_range(1, 40));
      endcase
      r.wb = int'($urandom_range(1, int'(r.l) + 1));
      r.wn = int'($urandom_range(0, 3));
      r.eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, int'(r.l) + 1)) : 0;
      ekind = 2'($urandom_range(1, 3));
      r.xb = model_burst(r.a, int'(r.l));
      r.seed = $urandom;
      run_cmd(r);
    end

    // reset in the middle of an INCR16 read
    ekind = 2'b01;
    @(negedge HCLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0500; cmd_len = 8'd15;
    @(posedge HCLK);
    #1 cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge HCLK);
      HREADY = 1'b1; HRESP = 2'b00; HRDATA = $urandom | 32'h1;
    end
    #2 HRESET = 1'b1;
    #1;
    check("mid_rst_htrans", 32'(HTRANS), 32'd0);
    check("mid_rst_haddr", HADDR, 32'd0);
    check("mid_rst_hwrite", 32'(HWRITE), 32'd0);
    check("mid_rst_hburst", 32'(HBURST), 32'd0);
    check("mid_rst_hwdata", HWDATA, 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    check("mid_rst_rdata_valid", 32'(rdata_valid), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_wdata_ack", 32'(wdata_ack), 32'd0);
    check("mid_rst_hsize", 32'(HSIZE), 32'd2);
    for (int i = 0; i < 2; i++) begin
      @(negedge HCLK);
      check("no_done_in_reset", 32'(done), 32'd0);
    end
    HRESET = 1'b0;
    #1 check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      check("no_done_after_rst", 32'(done), 32'd0);
    end
    run_cmd('{1'b0, 32'h0000_0500, 8'd15, 0, 0, 0, 3'b111, 32'h0});
    run_cmd('{1'b1, 32'h0000_0600, 8'd3, 0, 0, 0, 3'b011, 32'h5555_0000});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
